// File: rtl/seq_mag_comparator.sv
// ---------------------------------------------------------------------------
// seq_mag_comparator
//   Multi-cycle magnitude comparator for wide operands. The operands are
//   latched into shift registers and compared CHUNK bits per cycle, most
//   significant chunk first. Comparison stops at the first differing chunk,
//   so the latency is the 1-based index of that chunk (NCHUNK when equal).
//
//   Optional feature macro: COMP_SIGNED_EN
//     defined   -> 'sgn' port exists; sgn=1 selects two's-complement order
//                  (the MSB chunk is compared as signed, the rest unsigned).
//     undefined -> no 'sgn' port; every compare is unsigned.
//
// Parameters
//   WIDTH  operand width, integer multiple of CHUNK
//   CHUNK  bits compared per cycle
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous reset, active-high
//   in_valid   operands valid
//   in_ready   high in IDLE only
//   in1, in2   operands A and B
//   sgn        signed compare select (COMP_SIGNED_EN only)
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts result
//   g, e, l    one-hot A>B, A==B, A<B
//   out        result code: 01 greater, 10 equal, 00 less
// ---------------------------------------------------------------------------
module seq_mag_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
`ifdef COMP_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             g,
    output logic             e,
    output logic             l,
    output logic [1:0]       out
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(NCHUNK - 1);
    localparam logic [CHUNK-1:0] SIGN_BIT = CHUNK'(1) << (CHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             sgn_reg, sgn_next;
    logic             g_reg, g_next;
    logic             e_reg, e_next;
    logic             l_reg, l_next;
    logic [1:0]       out_reg, out_next;

    logic             sgn_in;
    logic             msb_flip;
    logic [CHUNK-1:0] top_a, top_b;

`ifdef COMP_SIGNED_EN
    assign sgn_in = sgn;
`else
    assign sgn_in = 1'b0;
`endif

    // The counter only equals CNT_LAST on the first CMP cycle, i.e. while
    // the MSB chunk sits at the top of the shift registers. Inverting the
    // sign bit of both chunks turns a signed compare into an unsigned one.
    assign msb_flip = sgn_reg && (cnt_reg == CNT_LAST);
    assign top_a    = a_reg[WIDTH-1 -: CHUNK] ^ (msb_flip ? SIGN_BIT : '0);
    assign top_b    = b_reg[WIDTH-1 -: CHUNK] ^ (msb_flip ? SIGN_BIT : '0);

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        cnt_next   = cnt_reg;
        sgn_next   = sgn_reg;
        g_next     = g_reg;
        e_next     = e_reg;
        l_next     = l_reg;
        out_next   = out_reg;
        in_ready   = (state_reg == IDLE);
        out_valid  = (state_reg == DONE);

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next     = in1;
                    b_next     = in2;
                    sgn_next   = sgn_in;
                    cnt_next   = CNT_LAST;
                    state_next = CMP;
                end
            end
            CMP: begin
                if (top_a != top_b) begin
                    g_next     = (top_a > top_b);
                    e_next     = 1'b0;
                    l_next     = (top_a < top_b);
                    out_next   = (top_a > top_b) ? 2'b01 : 2'b00;
                    state_next = DONE;
                end else if (cnt_reg != '0) begin
                    a_next   = a_reg << CHUNK;
                    b_next   = b_reg << CHUNK;
                    cnt_next = cnt_reg - CW'(1);
                end else begin
                    g_next     = 1'b0;
                    e_next     = 1'b1;
                    l_next     = 1'b0;
                    out_next   = 2'b10;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            cnt_reg   <= '0;
            sgn_reg   <= 1'b0;
            g_reg     <= 1'b0;
            e_reg     <= 1'b0;
            l_reg     <= 1'b0;
            out_reg   <= 2'b00;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            cnt_reg   <= cnt_next;
            sgn_reg   <= sgn_next;
            g_reg     <= g_next;
            e_reg     <= e_next;
            l_reg     <= l_next;
            out_reg   <= out_next;
        end
    end

    assign g   = g_reg;
    assign e   = e_reg;
    assign l   = l_reg;
    assign out = out_reg;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// ---------------------------------------------------------------------------
// tb_seq_mag_comparator
//   Directed vectors for seq_mag_comparator (WIDTH=32, CHUNK=8) with a
//   transaction-level reference model checked every cycle, plus literal
//   expectations for result code, one-hot flags and latency.
// ---------------------------------------------------------------------------
module tb_seq_mag_comparator;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;
`ifdef COMP_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             sgn = 1'b0;
    logic [WIDTH-1:0] in1 = '0;
    logic [WIDTH-1:0] in2 = '0;
    logic             in_ready, out_valid, g, e, l;
    logic [1:0]       out;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_mag_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
`ifdef COMP_SIGNED_EN
        .sgn       (sgn),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .g         (g),
        .e         (e),
        .l         (l),
        .out       (out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic ordering of the whole operands.
    function automatic logic [1:0] ref_code(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic s);
        if (s && SIGNED_BUILD) begin
            if ($signed(a) > $signed(b)) return 2'b01;
            if ($signed(a) < $signed(b)) return 2'b00;
            return 2'b10;
        end
        if (a > b) return 2'b01;
        if (a < b) return 2'b00;
        return 2'b10;
    endfunction

    // Reference latency: 1-based index of first differing chunk from the MSB.
    function automatic int ref_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        for (int i = 0; i < NCHUNK; i++) begin
            if (a[WIDTH-1-CHUNK*i -: CHUNK] != b[WIDTH-1-CHUNK*i -: CHUNK]) return i + 1;
        end
        return NCHUNK;
    endfunction

    // Model: 0 idle, 1 computing (m_left cycles to go), 2 holding result.
    int         m_state = 0;
    int         m_left  = 0;
    logic [1:0] m_pend  = 2'b00;
    logic [1:0] m_out   = 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            m_state <= 0;
            m_left  <= 0;
            m_out   <= 2'b00;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    m_pend  <= ref_code(in1, in2, sgn);
                    m_left  <= ref_lat(in1, in2);
                    m_state <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_state <= 2;
                        m_out   <= m_pend;
                    end
                end
                default: if (out_ready) m_state <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model in_ready", {31'd0, in_ready}, {31'd0, m_state == 0});
            check("model out_valid", {31'd0, out_valid}, {31'd0, m_state == 2});
            if (m_state == 2) begin
                check("model out", {30'd0, out}, {30'd0, m_out});
                check("model gel", {29'd0, g, e, l},
                      {29'd0, m_out == 2'b01, m_out == 2'b10, m_out == 2'b00});
            end
        end
    end

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [1:0] exp_out, input logic [2:0] exp_gel, input int exp_k);
        int cyc;
        @(posedge clk); #1;
        in1 = a; in2 = b; sgn = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in1 = ~a; in2 = 32'h0; sgn = ~s;   // must not disturb the latched operands
        wait_result(cyc);
        check("latency", cyc, exp_k);
        check("out", {30'd0, out}, {30'd0, exp_out});
        check("gel", {29'd0, g, e, l}, {29'd0, exp_gel});
        $display("op %08h vs %08h sgn=%0d -> out=%b gel=%b%b%b latency=%0d",
                 a, b, s, out, g, e, l, cyc);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset gel", {29'd0, g, e, l}, 32'd0);
        check("reset out", {30'd0, out}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_op(32'h12345678, 32'h02345678, 1'b0, 2'b01, 3'b100, 1);
        run_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2'b10, 3'b010, 4);
        run_op(32'h00000001, 32'h00000002, 1'b0, 2'b00, 3'b001, 4);
        run_op(32'h0000FF00, 32'h00010000, 1'b0, 2'b00, 3'b001, 2);
        run_op(32'h00000100, 32'h000000FF, 1'b0, 2'b01, 3'b100, 3);
        run_op(32'h80000000, 32'h7FFFFFFF, 1'b0, 2'b01, 3'b100, 1);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 2'b01, 3'b100, 1);
`ifdef COMP_SIGNED_EN
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b1, 2'b00, 3'b001, 1);
        run_op(32'h80000000, 32'h7FFFFFFF, 1'b1, 2'b00, 3'b001, 1);
        run_op(32'hFFFFFF00, 32'hFFFFFF01, 1'b1, 2'b00, 3'b001, 4);
`else
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b1, 2'b01, 3'b100, 1);
`endif

        // Back-pressure: hold the result for 5 cycles while offering new operands.
        @(posedge clk); #1;
        in1 = 32'h00000001; in2 = 32'h00000002; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(cyc);
        check("hold latency", cyc, 4);
        in1 = 32'h00000005; in2 = 32'h00000003; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold out_valid", {31'd0, out_valid}, 32'd1);
            check("hold out", {30'd0, out}, 32'd0);
            check("hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post-handshake in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(cyc);
        check("queued latency", cyc, 4);
        check("queued out", {30'd0, out}, 32'd1);
        $display("held op then 00000005 vs 00000003 -> out=%b latency=%0d", out, cyc);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset two cycles into CMP on equal operands.
        @(posedge clk); #1;
        in1 = 32'hDEADBEEF; in2 = 32'hDEADBEEF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort gel", {29'd0, g, e, l}, 32'd0);
        check("abort out", {30'd0, out}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort no stale", {31'd0, out_valid}, 32'd0);
        end
        $display("reset mid-CMP -> in_ready=%0d out_valid=%0d", in_ready, out_valid);

        run_op(32'hA5000000, 32'hA5000001, 1'b0, 2'b00, 3'b001, 4);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
